// File: rtl/decode_unescape_buffer.sv
// Byte-serial decoder front end: strips legacy prefixes and one 0x0F escape.
// Optional feature macro: DECODE_ARCH_LEN_CHECK_EN (total-length check).
module decode_unescape_buffer #(
    parameter int MAX_BODY  = 11,
    parameter int MAX_INSTR = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*MAX_BODY-1:0] unescaped_instr,
    output logic                  is_2byte,
    output logic [3:0]            body_len,
    output logic [5:0]            prefixes,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_PREFIX,
        S_BODY,
        S_HOLD
    } state_t;

    // A body can never be longer than a whole instruction.
    localparam int BODY_CAP =
        (MAX_BODY < MAX_INSTR) ? MAX_BODY : MAX_INSTR;
    localparam logic [3:0] CAP = 4'(BODY_CAP);

    state_t                  state, state_n;
    logic [8*MAX_BODY-1:0]   win, win_n;
    logic                    is2, is2_n;
    logic [3:0]              blen, blen_n;
    logic [5:0]              pfx, pfx_n;
    logic                    err_r, err_n;
    logic                    accept;
    logic [5:0]              flag;

`ifdef DECODE_ARCH_LEN_CHECK_EN
    logic [3:0]              total_cnt, total_cnt_n;
`endif

    function automatic logic [5:0] pfx_flag(input logic [7:0] b);
        logic [5:0] f;
        f = 6'b000000;
        case (b)
            8'h66: f = 6'b000001;
            8'h67: f = 6'b000010;
            8'hF0: f = 6'b000100;
            8'hF2: f = 6'b001000;
            8'hF3: f = 6'b010000;
            8'h26, 8'h2E, 8'h36,
            8'h3E, 8'h64, 8'h65: f = 6'b100000;
            default: f = 6'b000000;
        endcase
        return f;
    endfunction

    assign accept = in_valid && in_ready;
    assign flag   = pfx_flag(in_byte);

    // Next-state and accumulator update for the current byte.
    always_comb begin
        state_n = state;
        win_n   = win;
        is2_n   = is2;
        blen_n  = blen;
        pfx_n   = pfx;
        err_n   = err_r;
`ifdef DECODE_ARCH_LEN_CHECK_EN
        total_cnt_n = total_cnt;
`endif
        case (state)
            S_PREFIX: begin
                if (accept) begin
                    if (flag != 6'b000000) begin
                        pfx_n = pfx | flag;
                    end else if (in_byte == 8'h0F) begin
                        is2_n   = 1'b1;
                        state_n = S_BODY;
                    end else begin
                        win_n[7:0] = in_byte;
                        blen_n     = 4'd1;
                        state_n    = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (accept) begin
                    if (blen >= CAP) begin
                        err_n = 1'b1;
                    end else begin
                        win_n[8*blen +: 8] = in_byte;
                        blen_n = blen + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_n = S_PREFIX;
                    win_n   = '0;
                    is2_n   = 1'b0;
                    blen_n  = 4'd0;
                    pfx_n   = 6'b000000;
                    err_n   = 1'b0;
`ifdef DECODE_ARCH_LEN_CHECK_EN
                    total_cnt_n = 4'd0;
`endif
                end
            end
            default: state_n = S_PREFIX;
        endcase

`ifdef DECODE_ARCH_LEN_CHECK_EN
        if (accept) begin
            if (total_cnt >= 4'(MAX_INSTR)) begin
                err_n = 1'b1;
            end
            if (total_cnt != 4'hF) begin
                total_cnt_n = total_cnt + 4'd1;
            end
        end
`endif

        if (accept && in_last) begin
            state_n = S_HOLD;
            if (blen_n == 4'd0) begin
                err_n = 1'b1;
            end
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_PREFIX;
            win   <= '0;
            is2   <= 1'b0;
            blen  <= 4'd0;
            pfx   <= 6'b000000;
            err_r <= 1'b0;
`ifdef DECODE_ARCH_LEN_CHECK_EN
            total_cnt <= 4'd0;
`endif
        end else begin
            state <= state_n;
            win   <= win_n;
            is2   <= is2_n;
            blen  <= blen_n;
            pfx   <= pfx_n;
            err_r <= err_n;
`ifdef DECODE_ARCH_LEN_CHECK_EN
            total_cnt <= total_cnt_n;
`endif
        end
    end

    assign in_ready        = (state != S_HOLD);
    assign out_valid       = (state == S_HOLD);
    assign unescaped_instr = win;
    assign is_2byte        = is2;
    assign body_len        = blen;
    assign prefixes        = pfx;
    assign err             = err_r;

endmodule

// File: tb/tb_decode_unescape_buffer.sv
// Bench for decode_unescape_buffer: vector table, corner sequences,
// and random instructions against a queue-based reference model.
module tb_decode_unescape_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = 8'h00;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [87:0] unescaped_instr;
    logic        is_2byte;
    logic [3:0]  body_len;
    logic [5:0]  prefixes;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    decode_unescape_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_byte         (in_byte),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .unescaped_instr (unescaped_instr),
        .is_2byte        (is_2byte),
        .body_len        (body_len),
        .prefixes        (prefixes),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [87:0] win;
        logic [3:0]  len;
        logic [5:0]  pfx;
        logic        is2;
        logic        err;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  b[24];
        exp_t        e;
    } vec_t;

`ifdef DECODE_ARCH_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    vec_t        tbl[9];
    logic [7:0]  stim[$];

    task automatic chk(input string nm, input logic [87:0] act,
                       input logic [87:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] pfx_of(input logic [7:0] b);
        case (b)
            8'h66: return 6'd1;
            8'h67: return 6'd2;
            8'hF0: return 6'd4;
            8'hF2: return 6'd8;
            8'hF3: return 6'd16;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

    // Reference: split the byte list into prefixes / escape / body.
    function automatic exp_t model();
        exp_t       e;
        logic [7:0] body[$];
        bit         in_body;
        e = '{default: '0};
        in_body = 0;
        foreach (stim[i]) begin
            if (in_body) begin
                body.push_back(stim[i]);
            end else if (pfx_of(stim[i]) != 0) begin
                e.pfx |= pfx_of(stim[i]);
            end else if (stim[i] == 8'h0F) begin
                e.is2 = 1;
                in_body = 1;
            end else begin
                body.push_back(stim[i]);
                in_body = 1;
            end
        end
        for (int k = 0; k < body.size() && k < 11; k++)
            e.win[8*k +: 8] = body[k];
        e.len = (body.size() > 11) ? 4'd11 : 4'(body.size());
        if (body.size() > 11) e.err = 1;
        if (body.size() == 0) e.err = 1;
        if (LEN_CHK && stim.size() > 15) e.err = 1;
        return e;
    endfunction

    task automatic send(input bit gaps);
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_byte  = stim[i];
            in_last  = (i == stim.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic compare_out(input string nm, input exp_t e);
        chk({nm, ".out_valid"}, 88'(out_valid), 88'(1'b1));
        chk({nm, ".in_ready"}, 88'(in_ready), 88'(1'b0));
        chk({nm, ".instr"}, unescaped_instr, e.win);
        chk({nm, ".len"}, 88'(body_len), 88'(e.len));
        chk({nm, ".pfx"}, 88'(prefixes), 88'(e.pfx));
        chk({nm, ".is2"}, 88'(is_2byte), 88'(e.is2));
        chk({nm, ".err"}, 88'(err), 88'(e.err));
    endtask

    task automatic release_out(input string nm, input int delay);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".ov_clr"}, 88'(out_valid), 88'(1'b0));
        chk({nm, ".ir_back"}, 88'(in_ready), 88'(1'b1));
        chk({nm, ".win_clr"}, unescaped_instr, 88'h0);
    endtask

    task automatic set_vec(input int idx, input int n, input logic [191:0] bs,
                           input logic [87:0] w, input logic [3:0] l,
                           input logic [5:0] p, input logic i2, input logic er);
        tbl[idx].n = n;
        for (int k = 0; k < 24; k++) tbl[idx].b[k] = bs[8*k +: 8];
        tbl[idx].e = '{win: w, len: l, pfx: p, is2: i2, err: er};
    endtask

    exp_t        e;
    exp_t        snap;
    logic [191:0] bs;

    initial begin
        bs = 192'h0C0B0A090807060504030201;
        set_vec(0, 3, 192'hC88966, 88'hC889, 4'd2, 6'b000001, 0, 0);
        set_vec(1, 3, 192'h0F0F0F, 88'h0F0F, 4'd2, 6'b000000, 1, 0);
        set_vec(2, 12, bs, 88'h0B0A0908070605040302_01, 4'd11,
                6'b000000, 0, 1);
        set_vec(3, 1, 192'h90, 88'h90, 4'd1, 6'b000000, 0, 0);
        set_vec(4, 1, 192'hF0, 88'h0, 4'd0, 6'b000100, 0, 1);
        bs = '0;
        for (int k = 0; k < 14; k++) bs[8*k +: 8] = 8'h3E;
        bs[8*14 +: 16] = 16'h9090;
        set_vec(5, 16, bs, 88'h9090, 4'd2, 6'b100000, 0, LEN_CHK);
        bs = '0;
        for (int k = 0; k < 20; k++) bs[8*k +: 8] = 8'h2E;
        bs[8*20 +: 8] = 8'h90;
        set_vec(6, 21, bs, 88'h90, 4'd1, 6'b100000, 0, LEN_CHK);
        set_vec(7, 8, 192'h0F0F26F3F2F06766, 88'h0F, 4'd1,
                6'b111111, 1, 0);
        set_vec(8, 1, 192'hC3, 88'hC3, 4'd1, 6'b000000, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 88'(in_ready), 88'(1'b1));
        chk("rst.out_valid", 88'(out_valid), 88'(1'b0));
        chk("rst.instr", unescaped_instr, 88'h0);
        chk("rst.len", 88'(body_len), 88'h0);
        chk("rst.pfx", 88'(prefixes), 88'h0);
        chk("rst.is2", 88'(is_2byte), 88'h0);
        chk("rst.err", 88'(err), 88'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 9; t++) begin
            stim.delete();
            for (int k = 0; k < tbl[t].n; k++) stim.push_back(tbl[t].b[k]);
            send(0);
            compare_out($sformatf("tbl%0d", t), tbl[t].e);
            release_out($sformatf("tbl%0d", t), 0);
        end

        // Stall under back-pressure with a byte offered.
        stim = '{8'hF3, 8'h0F, 8'hB8, 8'hC1};
        send(0);
        e = '{win: 88'hC1B8, len: 4'd2, pfx: 6'b010000, is2: 1, err: 0};
        compare_out("hold", e);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        in_last  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            compare_out("hold_stall", e);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_out("hold", 0);

        // Reset in the middle of an instruction.
        stim = '{8'h66, 8'h0F, 8'h12};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_byte  = stim[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.instr", unescaped_instr, 88'h0);
        chk("mrst.pfx", 88'(prefixes), 88'h0);
        chk("mrst.is2", 88'(is_2byte), 88'h0);
        chk("mrst.len", 88'(body_len), 88'h0);
        chk("mrst.in_ready", 88'(in_ready), 88'(1'b1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stim = '{8'hC3};
        send(0);
        e = '{win: 88'hC3, len: 4'd1, pfx: 6'd0, is2: 0, err: 0};
        compare_out("mrst_next", e);
        release_out("mrst_next", 0);

        // Random instructions with input gaps and output stalls.
        for (int r = 0; r < 60; r++) begin
            logic [7:0] pl[$];
            int np, nb;
            pl = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26,
                   8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
            stim.delete();
            np = $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0) np = $urandom_range(10, 16);
            for (int k = 0; k < np; k++)
                stim.push_back(pl[$urandom_range(0, 10)]);
            if ($urandom_range(0, 2) == 0) stim.push_back(8'h0F);
            nb = $urandom_range(0, 13);
            for (int k = 0; k < nb; k++)
                stim.push_back(8'($urandom_range(0, 255)));
            if (stim.size() == 0) stim.push_back(8'h90);
            snap = model();
            send(1);
            compare_out($sformatf("rnd%0d", r), snap);
            release_out($sformatf("rnd%0d", r), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
